// File: rtl/dsp_seq_pkg.sv
// Shared definitions for the MAC sequencer that drives an 8-bit dsp_slice.
// Holds the FSM state type, the slice mode encodings, and the number of
// cycles needed to flush the slice's two-stage MAC pipeline.
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_t;

  localparam logic [2:0] MODE_ADD = 3'b001;
  localparam logic [2:0] MODE_MUL = 3'b010;
  localparam logic [2:0] MODE_MAC = 3'b100;

  // Cycles from the last accepted pair until c_out holds the final sum.
  localparam int DRAIN_CYC = 3;

  localparam int DWIDTH_DEF = 8;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: runs one dot-product job on a dsp_slice in MAC mode.
// A job starts with start/cfg_len in IDLE, clears the slice, streams
// cfg_len operand pairs into it, waits for the pipeline to drain, then
// holds the slice accumulator on res_data until res_ready.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, cfg_len          job request and pair count (sampled in IDLE)
//   busy                    high whenever not IDLE
//   in_valid/in_ready       operand pair handshake, in_a/in_b signed
//   dsp_a_in/dsp_b_in       operands to the slice (0 when no pair)
//   dsp_mode/dsp_carry_in   constant MAC mode, carry 0
//   dsp_reset               slice sync reset (reset or CLEAR state)
//   dsp_c_out               slice accumulator
//   res_valid/res_ready     result handshake, res_data the result
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  output logic [DWIDTH-1:0] dsp_a_in,
  output logic [DWIDTH-1:0] dsp_b_in,
  output logic [2:0]        dsp_mode,
  output logic              dsp_reset,
  output logic              dsp_carry_in,
  input  logic [DWIDTH-1:0] dsp_c_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DWIDTH-1:0] res_data
);

  localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYC - 1);

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [DCNT_W-1:0]  r_dcnt;
  logic [DWIDTH-1:0]  r_res_data;
  logic               w_feed_hs;
  logic               w_last_pair;
  logic               w_last_drain;

  assign w_feed_hs    = (r_state == S_FEED) && in_valid;
  assign w_last_pair  = (r_cnt == (r_len - LEN_W'(1)));
  assign w_last_drain = (r_dcnt == DCNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (cfg_len != '0) ? S_CLEAR : S_HOLD;
        end
      end
      S_CLEAR: w_next = S_FEED;
      S_FEED: begin
        if (w_feed_hs && w_last_pair) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_drain) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_dcnt     <= '0;
      r_res_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (cfg_len != '0) begin
              r_len <= cfg_len;
            end else begin
              r_res_data <= '0;
            end
          end
        end
        S_CLEAR: r_cnt <= '0;
        S_FEED: begin
          if (w_feed_hs) begin
            r_cnt <= r_cnt + LEN_W'(1);
            if (w_last_pair) begin
              r_dcnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          r_dcnt <= r_dcnt + DCNT_W'(1);
          // The last pair has reached the accumulator by now.
          if (w_last_drain) begin
            r_res_data <= dsp_c_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign in_ready     = (r_state == S_FEED);
  assign res_valid    = (r_state == S_HOLD);
  assign res_data     = r_res_data;
  // Bubbles feed 0*0, which leaves the accumulator untouched.
  assign dsp_a_in     = w_feed_hs ? in_a : '0;
  assign dsp_b_in     = w_feed_hs ? in_b : '0;
  assign dsp_mode     = MODE_MAC;
  assign dsp_carry_in = 1'b0;
  assign dsp_reset    = ~reset_n | (r_state == S_CLEAR);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
module tb_dsp_mac_sequencer;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [LW-1:0] cfg_len;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a, in_b;
  logic [DW-1:0] dsp_a_in, dsp_b_in;
  logic [2:0]    dsp_mode;
  logic          dsp_reset;
  logic          dsp_carry_in;
  logic [DW-1:0] dsp_c_out;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.DWIDTH(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_len(cfg_len),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .dsp_a_in(dsp_a_in), .dsp_b_in(dsp_b_in),
    .dsp_mode(dsp_mode), .dsp_reset(dsp_reset), .dsp_carry_in(dsp_carry_in),
    .dsp_c_out(dsp_c_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  // Saturating signed product, as the slice's multiplier produces it.
  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Behavioural dsp_slice in MAC mode: product register, then wrapping acc.
  logic [7:0] s_mult, s_acc;
  always @(posedge clk) begin
    if (dsp_reset) begin
      s_mult <= 8'd0;
      s_acc  <= 8'd0;
    end else if (dsp_mode == 3'b100) begin
      s_mult <= 8'(sat8(int'($signed(dsp_a_in)) * int'($signed(dsp_b_in))));
      s_acc  <= s_acc + s_mult;
    end
  end
  assign dsp_c_out = s_acc;

  int cyc = 0;
  int rst_hi = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dsp_reset) rst_hi <= rst_hi + 1;

  int n_chk = 0;
  int n_pass = 0;
  int ja[16];
  int jb[16];
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Dot product of the current job: saturated products, 8-bit wrapping sum.
  function automatic logic [7:0] ref_dot(input int n);
    logic [7:0] acc;
    acc = 8'd0;
    for (int i = 0; i < n; i++) acc = acc + 8'(sat8(ja[i] * jb[i]));
    return acc;
  endfunction

  // Every cycle a result is offered, it must match the oldest expected job.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("res_valid_unexpected", {31'd0, res_valid}, 32'd0);
        end else begin
          chk("res_data_model", {24'd0, res_data}, {24'd0, exp_q[0]});
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int n, input int bub, input int hold,
                         input bit chk_lat, input bit poke, output logic [7:0] got);
    int t0;
    int w;
    res_ready = 1'b0;
    exp_q.push_back(ref_dot(n));
    start = 1'b1;
    cfg_len = LW'(n);
    tick;
    start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int b = 0; b < bub; b++) begin
          in_valid = 1'b0;
          in_a = 8'd0;
          in_b = 8'd0;
          chk("bubble_in_ready", {31'd0, in_ready}, 32'd1);
          tick;
        end
      end
      in_valid = 1'b1;
      in_a = 8'(ja[i]);
      in_b = 8'(jb[i]);
      w = 0;
      while (!in_ready && w < 20) begin
        tick;
        w++;
      end
      if (w >= 20) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      tick;
    end
    in_valid = 1'b0;
    in_a = 8'd0;
    in_b = 8'd0;
    w = 0;
    while (!res_valid && w < 60) begin
      tick;
      w++;
    end
    chk("res_valid_seen", {31'd0, res_valid}, 32'd1);
    if (chk_lat) chk("latency", cyc - t0, (n == 0) ? 0 : n + 1 + 3);
    got = res_data;
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        start = 1'b1;
        cfg_len = 8'd5;
      end
      tick;
      start = 1'b0;
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_data", {24'd0, res_data}, {24'd0, got});
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("valid_drop", {31'd0, res_valid}, 32'd0);
    chk("idle_after_ready", {31'd0, busy}, 32'd0);
    chk("data_kept", {24'd0, res_data}, {24'd0, got});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int snap;
    reset_n = 1'b0;
    start = 1'b0;
    cfg_len = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b0;
    tick;
    tick;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {24'd0, res_data}, 32'd0);
    chk("rst_dsp_reset", {31'd0, dsp_reset}, 32'd1);
    reset_n = 1'b1;
    tick;
    chk("dsp_mode", {29'd0, dsp_mode}, 32'd4);
    chk("dsp_carry", {31'd0, dsp_carry_in}, 32'd0);
    chk("idle_dsp_reset", {31'd0, dsp_reset}, 32'd0);

    // Basic dot product
    ja[0] = 2;  jb[0] = 3;
    ja[1] = 4;  jb[1] = 5;
    ja[2] = -1; jb[2] = 6;
    chk("model_basic", {24'd0, ref_dot(3)}, 32'd20);
    run_job(3, 0, 0, 1'b1, 1'b0, got);
    chk("basic_result", {24'd0, got}, 32'd20);

    // Same stimulus with two bubble cycles between pairs
    run_job(3, 2, 0, 1'b0, 1'b0, got);
    chk("bubble_result", {24'd0, got}, 32'd20);

    // Saturate then wrap
    ja[0] = 100; jb[0] = 100;
    ja[1] = 1;   jb[1] = 1;
    chk("model_sat", {24'd0, ref_dot(2)}, 32'h80);
    run_job(2, 0, 0, 1'b1, 1'b0, got);
    chk("sat_wrap_result", {24'd0, got}, 32'h80);

    // Zero-length job: immediate result, slice never reset
    snap = rst_hi;
    run_job(0, 0, 0, 1'b1, 1'b0, got);
    chk("zero_result", {24'd0, got}, 32'd0);
    chk("zero_no_dsp_reset", rst_hi - snap, 32'd0);

    // Backpressure with an ignored start pulse during HOLD
    ja[0] = 3; jb[0] = 4;
    ja[1] = 5; jb[1] = -2;
    run_job(2, 0, 5, 1'b1, 1'b1, got);
    chk("bp_result", {24'd0, got}, 32'd2);
    tick;
    chk("bp_start_ignored", {31'd0, busy}, 32'd0);

    // Reset in the middle of FEED, then a fresh job
    start = 1'b1;
    cfg_len = 8'd4;
    tick;
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 8'd9;
    in_b = 8'd9;
    while (!in_ready) tick;
    tick;
    tick;
    in_valid = 1'b0;
    in_a = 8'd0;
    in_b = 8'd0;
    chk("midjob_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_dsp_reset", {31'd0, dsp_reset}, 32'd1);
    chk("abort_res_data", {24'd0, res_data}, 32'd0);
    tick;
    reset_n = 1'b1;
    tick;
    ja[0] = 7; jb[0] = -3;
    chk("model_neg", {24'd0, ref_dot(1)}, 32'hEB);
    run_job(1, 0, 0, 1'b1, 1'b0, got);
    chk("after_abort_result", {24'd0, got}, 32'hEB);

    // Randomised jobs against the model
    for (int j = 0; j < 25; j++) begin
      int n, bub, hold;
      n = int'($urandom_range(1, 8));
      bub = int'($urandom_range(0, 2));
      hold = int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
        ja[i] = int'($urandom_range(0, 255)) - 128;
        jb[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_job(n, bub, hold, (bub == 0), 1'b0, got);
      if (($urandom_range(0, 1)) == 1) tick;
    end

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
Upstream/downstream controller for the 8-bit dsp_slice operating in MAC mode (mode=3'b100). It accepts a stream of signed operand pairs over a valid/ready interface and drives the slice's a_in/b_in/mode/reset/carry_in inputs. It tracks the slice's two-stage MAC pipeline, captures the final accumulator from c_out, and presents one dot-product result per job over a valid/ready output.

Parameters:
DWIDTH, 8, operand/result width; must match the slice.
LEN_W, 8, width of the vector-length field; max job length 2^LEN_W-1.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
cfg_len  in  LEN_W  number of operand pairs in the job; sampled with start
busy  out  1  high in every state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer accepts a pair this cycle
in_a  in  DWIDTH  signed operand A
in_b  in  DWIDTH  signed operand B
dsp_a_in  out  DWIDTH  to slice a_in
dsp_b_in  out  DWIDTH  to slice b_in
dsp_mode  out  3  to slice mode; constant MODE_MAC = 3'b100
dsp_reset  out  1  to slice reset (sync, active-high)
dsp_carry_in  out  1  to slice carry_in; constant 0
dsp_c_out  in  DWIDTH  from slice c_out (the accumulator in MAC mode)
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  DWIDTH  captured accumulator value

Behaviour:
- Reset (reset_n low, async): state=IDLE, len/cnt/drain counters=0, res_data=0, res_valid=0, in_ready=0, busy=0. dsp_reset = ~reset_n OR (state==CLEAR), so it is high throughout reset.
- dsp_a_in/dsp_b_in = in_a/in_b when state==FEED && in_valid; otherwise 0. Bubbles therefore inject 0*0 products, which do not change the accumulator.
- Slice timing: a pair sampled at edge E reaches out_mult_reg at E+1 and the accumulator at E+2. c_out is valid in the cycle after E+2.
- States:
  - IDLE:
    - start && cfg_len!=0 -> latch len; go to CLEAR.
    - start && cfg_len==0 -> res_data<=0; go to HOLD.
    - start outside IDLE is ignored.
  - CLEAR (1 cycle): dsp_reset=1, clearing the slice accumulator and pipeline registers. Next state: FEED, cnt=0.
  - FEED:
    - in_ready=1.
    - On handshake (in_valid && in_ready): cnt++.
    - Handshake with cnt==len-1 -> DRAIN, dcnt=0.
  - DRAIN (DRAIN_CYC=3 cycles): in_ready=0, operands 0. In the last DRAIN cycle, res_data<=dsp_c_out; go to HOLD.
  - HOLD:
    - res_valid=1; res_data stable.
    - On res_ready -> IDLE. res_valid drops the next cycle; res_data keeps its value.
- Arithmetic: no extra processing. res_data is exactly the slice's 8-bit wrapping accumulator, including the saturated-multiply behaviour of the slice.
- Result latency: len+1+DRAIN_CYC cycles from start to res_valid, with no input bubbles.
- Reset mid-job: abort immediately to IDLE; any partial result is discarded; the slice is reset.
- Back-to-back: start may be asserted in the cycle after the HOLD->IDLE transition.

Decomposition:
- Package dsp_seq_pkg:
  - state enum {IDLE, CLEAR, FEED, DRAIN, HOLD}
  - MODE_ADD=3'b001, MODE_MUL=3'b010, MODE_MAC=3'b100
  - DRAIN_CYC=3
  - DWIDTH default
- Single module; no sub-module. The bench instantiates dsp_slice alongside it.

Test Plan:
- Basic dot product: len=3, pairs (2,3),(4,5),(-1,6) with in_valid continuous -> res_data=8'd20; res_valid exactly 7 cycles after start.
- Saturate then wrap: len=2, pairs (100,100),(1,1) -> 127+1 wraps; res_data=8'h80.
- Input bubbles: the basic-dot-product stimulus with in_valid low for 2 cycles between each pair -> res_data=20; in_ready stays high throughout FEED.
- Zero-length job: cfg_len=0 -> res_valid the cycle after start; res_data=0; dsp_reset never pulsed.
- Result backpressure: res_ready held low 5 cycles -> res_valid and res_data stable; a start pulse during HOLD is ignored; IDLE is entered only after res_ready.
- Reset mid-FEED: pulse reset_n low after 2 of 4 pairs, then run len=1 (7,-3) -> res_data=8'hEB (-21); no residue from the aborted job.
